// File: rtl/clk_src_switch_ctrl_pkg.sv
// Package for the clock source switch controller.
// Holds the FSM state type and the clock source encodings shared by the
// controller, its interface users and any software-visible models.
package clk_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_LOCK,
    SWITCH,
    SETTLE,
    DONE
  } clk_sw_state_e;

  localparam logic CLK_SRC_REF = 1'b0;
  localparam logic CLK_SRC_PLL = 1'b1;

endpackage

// File: rtl/clk_src_switch_ctrl_if.sv
// Request/response handshake bundle for the clock source switch controller.
//   req_valid_i  requester -> ctrl  switch request valid
//   req_sel_i    requester -> ctrl  requested source (0 = ref, 1 = PLL)
//   req_ready_o  ctrl -> requester  request accepted when valid && ready
//   rsp_valid_o  ctrl -> requester  one-cycle completion pulse
//   rsp_err_o    ctrl -> requester  qualifies rsp_valid_o; 1 = failed, sel is ref
interface clk_src_switch_ctrl_if;

  logic req_valid_i;
  logic req_sel_i;
  logic req_ready_o;
  logic rsp_valid_o;
  logic rsp_err_o;

  modport master (
    output req_valid_i,
    output req_sel_i,
    input  req_ready_o,
    input  rsp_valid_o,
    input  rsp_err_o
  );

  modport slave (
    input  req_valid_i,
    input  req_sel_i,
    output req_ready_o,
    output rsp_valid_o,
    output rsp_err_o
  );

endinterface

// File: rtl/clk_src_switch_ctrl_bit_sync.sv
// Single-bit multi-flop synchroniser.
//   clk_i   destination clock
//   arst_i  asynchronous reset, active-high; chain resets to 0
//   d_i     asynchronous input
//   q_o     synchronised output, STAGES cycles of latency
module bit_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk_i,
  input  logic arst_i,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/clk_src_switch_ctrl.sv
// Clock source switch controller: sequences the select of the glitch-free
// 2:1 root clock mux (source 0 = reference oscillator, source 1 = PLL).
// Runs on the reference clock, qualifies PLL lock before selecting the PLL,
// holds every select change for a settle window and falls back to the
// reference on its own when lock is lost while the PLL is (being) selected.
//   clk_i           reference clock (free-running)
//   arst_i          asynchronous reset, active-high
//   req_if          request/response handshake (slave side)
//   pll_lock_i      PLL lock, asynchronous to clk_i
//   sel_o           clock mux select
//   busy_o          high in every state except IDLE
//   fallback_o      sticky lock-loss fallback flag
//   fallback_clr_i  clears fallback_o; a same-cycle fallback event wins
module clk_src_switch_ctrl
  import clk_ctrl_pkg::*;
#(
  parameter int unsigned LOCK_STABLE_CYCLES = 64,
  parameter int unsigned SETTLE_CYCLES      = 8,
  parameter int unsigned TIMEOUT_CYCLES     = 4096,
  parameter int unsigned SYNC_STAGES        = 2
) (
  input  logic                  clk_i,
  input  logic                  arst_i,
  clk_src_switch_ctrl_if.slave  req_if,
  input  logic                  pll_lock_i,
  output logic                  sel_o,
  output logic                  busy_o,
  output logic                  fallback_o,
  input  logic                  fallback_clr_i
);

  localparam int unsigned STABLE_W  = $clog2(LOCK_STABLE_CYCLES + 1);
  localparam int unsigned TIMEOUT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned SETTLE_W  = $clog2(SETTLE_CYCLES + 1);

  localparam logic [STABLE_W-1:0]  STABLE_MAX  = STABLE_W'(LOCK_STABLE_CYCLES);
  localparam logic [TIMEOUT_W-1:0] TIMEOUT_MAX = TIMEOUT_W'(TIMEOUT_CYCLES);
  localparam logic [SETTLE_W-1:0]  SETTLE_LOAD = SETTLE_W'(SETTLE_CYCLES - 1);

  clk_sw_state_e        state_q,    state_d;
  logic                 sel_q,      sel_d;
  logic                 target_q,   target_d;
  logic                 err_q,      err_d;
  logic                 inflight_q, inflight_d;
  logic                 fallback_q, fallback_d;
  logic [STABLE_W-1:0]  stable_q,   stable_d;
  logic [TIMEOUT_W-1:0] timeout_q,  timeout_d;
  logic [SETTLE_W-1:0]  settle_q,   settle_d;

  logic                 lock_s;
  logic                 lock_lost;
  logic                 req_ready;
  logic                 accept;
  logic [STABLE_W-1:0]  stable_inc;
  logic [TIMEOUT_W-1:0] timeout_inc;

  bit_sync #(
    .STAGES (SYNC_STAGES)
  ) u_lock_sync (
    .clk_i  (clk_i),
    .arst_i (arst_i),
    .d_i    (pll_lock_i),
    .q_o    (lock_s)
  );

  // Saturating increments so the counters never wrap past their limit.
  assign stable_inc  = (stable_q  == STABLE_MAX)  ? stable_q  : stable_q  + 1'b1;
  assign timeout_inc = (timeout_q == TIMEOUT_MAX) ? timeout_q : timeout_q + 1'b1;

  // In SWITCH toward the PLL the mux has not moved yet, but the commit is
  // imminent, so a lost lock there is treated like a loss on the PLL.
  assign lock_lost = !lock_s &&
                     (((state_q == IDLE) && (sel_q == CLK_SRC_PLL)) ||
                      (((state_q == SWITCH) || (state_q == SETTLE)) &&
                       (target_q == CLK_SRC_PLL)));

  assign req_ready = (state_q == IDLE);
  // A fallback starting on the same edge drops the request even though
  // ready was visible to the requester.
  assign accept    = req_if.req_valid_i && req_ready && !lock_lost;

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q    <= IDLE;
      sel_q      <= CLK_SRC_REF;
      target_q   <= CLK_SRC_REF;
      err_q      <= 1'b0;
      inflight_q <= 1'b0;
      fallback_q <= 1'b0;
      stable_q   <= '0;
      timeout_q  <= '0;
      settle_q   <= '0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      target_q   <= target_d;
      err_q      <= err_d;
      inflight_q <= inflight_d;
      fallback_q <= fallback_d;
      stable_q   <= stable_d;
      timeout_q  <= timeout_d;
      settle_q   <= settle_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    target_d   = target_q;
    err_d      = err_q;
    inflight_d = inflight_q;
    fallback_d = fallback_q;
    stable_d   = stable_q;
    timeout_d  = timeout_q;
    settle_d   = settle_q;

    if (lock_lost) begin
      fallback_d = 1'b1;
    end else if (fallback_clr_i) begin
      fallback_d = 1'b0;
    end

    if (lock_lost) begin
      // Force the reference and re-run a full settle window. Retargeting
      // to the reference stops a persistently low lock from re-triggering.
      sel_d    = CLK_SRC_REF;
      target_d = CLK_SRC_REF;
      err_d    = err_q | inflight_q;
      settle_d = SETTLE_LOAD;
      state_d  = SETTLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            inflight_d = 1'b1;
            err_d      = 1'b0;
            target_d   = req_if.req_sel_i;
            if (req_if.req_sel_i == sel_q) begin
              state_d = DONE;
            end else if (req_if.req_sel_i == CLK_SRC_REF) begin
              state_d = SWITCH;
            end else begin
              stable_d  = '0;
              timeout_d = '0;
              state_d   = WAIT_LOCK;
            end
          end
        end

        WAIT_LOCK: begin
          stable_d  = lock_s ? stable_inc : '0;
          timeout_d = timeout_inc;
          // Lock qualification is checked first so it wins a tie.
          if (stable_d == STABLE_MAX) begin
            state_d = SWITCH;
          end else if (timeout_d == TIMEOUT_MAX) begin
            err_d   = 1'b1;
            state_d = DONE;
          end
        end

        SWITCH: begin
          sel_d    = target_q;
          settle_d = SETTLE_LOAD;
          state_d  = SETTLE;
        end

        SETTLE: begin
          if (settle_q == '0) begin
            // A fallback from IDLE has no requester to answer.
            state_d = inflight_q ? DONE : IDLE;
          end else begin
            settle_d = settle_q - 1'b1;
          end
        end

        DONE: begin
          inflight_d = 1'b0;
          state_d    = IDLE;
        end

        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  assign req_if.req_ready_o = req_ready;
  assign req_if.rsp_valid_o = (state_q == DONE);
  assign req_if.rsp_err_o   = (state_q == DONE) && err_q;
  assign sel_o              = sel_q;
  assign busy_o             = (state_q != IDLE);
  assign fallback_o         = fallback_q;

endmodule
